// File: rtl/interlaken_rx_pkg.sv
// interlaken_rx_pkg
//   Shared definitions for the Interlaken RX lane word-lock logic:
//   lock FSM state encoding, 64b/67b sync header codes, default
//   lock/monitor thresholds and a header validity helper.
package interlaken_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_SLIP = 2'd1,
        ST_WAIT = 2'd2,
        ST_LOCK = 2'd3
    } lock_state_e;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int DEF_LOCK_CNT   = 64;
    localparam int DEF_WINDOW_CNT = 64;
    localparam int DEF_UNLOCK_CNT = 16;
    localparam int DEF_SLIP_WAIT  = 32;

    function automatic logic sh_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   16-bit saturating event counter with synchronous clear.
//   Ports:
//     clk  in   clock
//     clr  in   synchronous clear, wins over inc
//     inc  in   count one event this cycle
//     cnt  out  current count, holds at 16'hFFFF
module sat_counter (
    input  logic        clk,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    logic [15:0] cnt_d;
    logic [15:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/interlaken_word_lock_ctrl.sv
// interlaken_word_lock_ctrl
//   Word-boundary lock controller for the Interlaken RX lane. Checks the
//   sync header of every strobed word from the gearbox, requests bit slips
//   until headers are consistently valid, declares lock, and drops lock
//   when too many bad headers appear within a monitoring window.
//   Ports:
//     USER_CLK         in   clock
//     RESET            in   synchronous active-high reset
//     DATA_IN[66:0]    in   gearbox word, [65:64] sync header, [66] unchecked
//     DATA_VALID       in   DATA_IN carries a new word
//     SLIP             out  one-cycle bit-slip request to the gearbox
//     LOCKED           out  word boundary locked
//     SLIP_COUNT       out  saturating count of SLIP pulses
//     LOCK_LOSS_COUNT  out  saturating count of lock losses
//   Macro INTERLAKEN_WORD_LOCK_STATS_EN builds the two statistics counters;
//   without it both statistics outputs read zero.
//
//   state | meaning
//   HUNT  | counting consecutive valid headers towards lock
//   SLIP  | single-cycle slip request, lock counters cleared
//   WAIT  | gearbox re-aligning, words ignored for SLIP_WAIT cycles
//   LOCK  | locked, bad headers counted per window
module interlaken_word_lock_ctrl
    import interlaken_rx_pkg::*;
#(
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int WINDOW_CNT = DEF_WINDOW_CNT,
    parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
    parameter int SLIP_WAIT  = DEF_SLIP_WAIT
) (
    input  logic        USER_CLK,
    input  logic        RESET,
    input  logic [66:0] DATA_IN,
    input  logic        DATA_VALID,
    output logic        SLIP,
    output logic        LOCKED,
    output logic [15:0] SLIP_COUNT,
    output logic [15:0] LOCK_LOSS_COUNT
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam int TW = $clog2(SLIP_WAIT + 1);

    // Compare against the value before the final increment so the
    // terminal word itself triggers the transition.
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW_CNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_CNT - 1);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(SLIP_WAIT - 1);

    lock_state_e   state_d, state_q;
    logic [GW-1:0] good_cnt_d, good_cnt_q;
    logic [WW-1:0] win_cnt_d, win_cnt_q;
    logic [BW-1:0] bad_cnt_d, bad_cnt_q;
    logic [TW-1:0] wait_cnt_d, wait_cnt_q;
    logic          slip_d, slip_q;
    logic          locked_d, locked_q;
    logic          hdr_ok;
    logic          unused_data;

    assign hdr_ok      = sh_valid(DATA_IN[65:64]);
    assign unused_data = ^{DATA_IN[66], DATA_IN[63:0]};

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        win_cnt_d  = win_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_HUNT: begin
                if (DATA_VALID) begin
                    if (!hdr_ok) begin
                        state_d    = ST_SLIP;
                        good_cnt_d = '0;
                    end else if (good_cnt_q == GOOD_LAST) begin
                        state_d    = ST_LOCK;
                        good_cnt_d = '0;
                        win_cnt_d  = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + GW'(1);
                    end
                end
            end
            ST_SLIP: begin
                state_d    = ST_WAIT;
                good_cnt_d = '0;
                win_cnt_d  = '0;
                bad_cnt_d  = '0;
                wait_cnt_d = WAIT_LOAD;
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d    = ST_HUNT;
                    good_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q - TW'(1);
                end
            end
            ST_LOCK: begin
                if (DATA_VALID) begin
                    // Loss of lock is tested before the window end so a
                    // final bad word on the last window slot still unlocks.
                    if (!hdr_ok && (bad_cnt_q == BAD_LAST)) begin
                        state_d   = ST_SLIP;
                        win_cnt_d = '0;
                        bad_cnt_d = '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        bad_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WW'(1);
                        if (!hdr_ok) begin
                            bad_cnt_d = bad_cnt_q + BW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
        slip_d   = (state_d == ST_SLIP);
        locked_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            state_q    <= ST_HUNT;
            good_cnt_q <= '0;
            win_cnt_q  <= '0;
            bad_cnt_q  <= '0;
            wait_cnt_q <= '0;
            slip_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            win_cnt_q  <= win_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            slip_q     <= slip_d;
            locked_q   <= locked_d;
        end
    end

    assign SLIP   = slip_q;
    assign LOCKED = locked_q;

`ifdef INTERLAKEN_WORD_LOCK_STATS_EN
    logic slip_inc;
    logic loss_inc;

    // Counters register the same next-state decode as SLIP, so they
    // change on the same edge the pulse appears.
    assign slip_inc = slip_d;
    assign loss_inc = (state_q == ST_LOCK) && (state_d == ST_SLIP);

    sat_counter u_slip_cnt (
        .clk (USER_CLK),
        .clr (RESET),
        .inc (slip_inc),
        .cnt (SLIP_COUNT)
    );

    sat_counter u_loss_cnt (
        .clk (USER_CLK),
        .clr (RESET),
        .inc (loss_inc),
        .cnt (LOCK_LOSS_COUNT)
    );
`else
    assign SLIP_COUNT      = 16'h0000;
    assign LOCK_LOSS_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_interlaken_word_lock_ctrl.sv
// tb_interlaken_word_lock_ctrl
//   Directed bench for interlaken_word_lock_ctrl. Expected SLIP pulses and
//   LOCKED edges are queued with the edge number at which they must appear;
//   a negedge monitor pops and compares each observed event. Level checks
//   cover reset values and statistics. A standalone sat_counter is driven
//   to saturation.
module tb_interlaken_word_lock_ctrl;
    import interlaken_rx_pkg::*;

    localparam int EV_SLIP = 0;
    localparam int EV_UP   = 1;
    localparam int EV_DN   = 2;

`ifdef INTERLAKEN_WORD_LOCK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        int kind;
        int edge_n;
    } exp_ev_t;

    logic        USER_CLK;
    logic        RESET;
    logic [66:0] DATA_IN;
    logic        DATA_VALID;
    logic        SLIP;
    logic        LOCKED;
    logic [15:0] SLIP_COUNT;
    logic [15:0] LOCK_LOSS_COUNT;

    logic        sat_clr;
    logic        sat_inc;
    logic [15:0] sat_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_num = 0;
    bit          mon_en   = 1'b0;
    logic        prev_locked = 1'b0;
    bit          tgl = 1'b0;
    exp_ev_t     exp_q[$];

    interlaken_word_lock_ctrl dut (
        .USER_CLK        (USER_CLK),
        .RESET           (RESET),
        .DATA_IN         (DATA_IN),
        .DATA_VALID      (DATA_VALID),
        .SLIP            (SLIP),
        .LOCKED          (LOCKED),
        .SLIP_COUNT      (SLIP_COUNT),
        .LOCK_LOSS_COUNT (LOCK_LOSS_COUNT)
    );

    sat_counter u_sat (
        .clk (USER_CLK),
        .clr (sat_clr),
        .inc (sat_inc),
        .cnt (sat_cnt)
    );

    initial USER_CLK = 1'b0;
    always #5 USER_CLK = ~USER_CLK;

    always @(posedge USER_CLK) edge_num <= edge_num + 1;

    function automatic logic [15:0] exp_stat(input int n);
        return STATS ? 16'(n) : 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input int k);
        exp_ev_t e;
        e.kind   = k;
        e.edge_n = edge_num;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k);
        exp_ev_t e;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL unexpected_event observed kind %0d at edge %0d expected none", k, edge_num);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            assert ((e.kind == k) && (e.edge_n == edge_num)) else begin
                n_errors++;
                $error("FAIL event observed kind %0d at edge %0d expected kind %0d at edge %0d",
                       k, edge_num, e.kind, e.edge_n);
            end
        end
    endtask

    always @(negedge USER_CLK) begin
        if (mon_en) begin
            if (LOCKED !== prev_locked) begin
                observe((LOCKED === 1'b1) ? EV_UP : EV_DN);
                prev_locked = LOCKED;
            end
            if (SLIP !== 1'b0) begin
                observe(EV_SLIP);
            end
        end
    end

    task automatic word(input logic v, input logic [1:0] h);
        DATA_VALID = v;
        DATA_IN    = {1'b0, h, $urandom, $urandom};
        @(posedge USER_CLK);
        #1;
    endtask

    task automatic good_word();
        word(1'b1, tgl ? SH_CTRL : SH_DATA);
        tgl = ~tgl;
    endtask

    // 64 consecutive good words; lock must appear on the edge sampling the last.
    task automatic acquire();
        for (int i = 0; i < 63; i++) good_word();
        good_word();
        expect_ev(EV_UP);
    endtask

    // Words arriving while the gearbox re-aligns must be ignored, even invalid ones.
    task automatic wait_ignored();
        for (int i = 0; i < 33; i++) word(1'b1, 2'b00);
    endtask

    task automatic do_reset(input bit was_locked);
        RESET = 1'b1;
        word(1'b0, 2'b00);
        if (was_locked) expect_ev(EV_DN);
        RESET = 1'b0;
    endtask

    initial begin
        RESET      = 1'b1;
        DATA_VALID = 1'b0;
        DATA_IN    = '0;
        sat_clr    = 1'b1;
        sat_inc    = 1'b0;
        repeat (3) word(1'b0, 2'b00);
        RESET  = 1'b0;
        mon_en = 1'b1;

        chk("reset_slip", {15'd0, SLIP}, 16'd0);
        chk("reset_locked", {15'd0, LOCKED}, 16'd0);
        chk("reset_slip_count", SLIP_COUNT, 16'd0);
        chk("reset_loss_count", LOCK_LOSS_COUNT, 16'd0);

        // Clean acquisition
        acquire();
        chk("acq_locked", {15'd0, LOCKED}, 16'd1);
        chk("acq_slip_count", SLIP_COUNT, 16'd0);

        // 15 bad headers in one window keeps lock
        for (int i = 0; i < 64; i++) begin
            if ((i % 4 == 0) && (i < 60)) word(1'b1, 2'b00);
            else good_word();
        end
        chk("win15_locked", {15'd0, LOCKED}, 16'd1);

        // 16 bad headers in the next window drops lock on the 16th
        for (int i = 0; i <= 60; i++) begin
            if (i % 4 == 0) word(1'b1, 2'b11);
            else good_word();
        end
        expect_ev(EV_DN);
        expect_ev(EV_SLIP);
        chk("loss_locked", {15'd0, LOCKED}, 16'd0);
        chk("loss_slip", {15'd0, SLIP}, 16'd1);
        chk("loss_loss_count", LOCK_LOSS_COUNT, exp_stat(1));
        chk("loss_slip_count", SLIP_COUNT, exp_stat(1));
        wait_ignored();

        // 16th bad header lands on the last word of the window
        acquire();
        for (int i = 0; i < 64; i++) begin
            if (i >= 48) word(1'b1, 2'b00);
            else good_word();
        end
        expect_ev(EV_DN);
        expect_ev(EV_SLIP);
        chk("tie_locked", {15'd0, LOCKED}, 16'd0);
        chk("tie_loss_count", LOCK_LOSS_COUNT, exp_stat(2));
        chk("tie_slip_count", SLIP_COUNT, exp_stat(2));
        wait_ignored();

        // Misaligned start
        do_reset(1'b0);
        chk("mis_reset_slip_count", SLIP_COUNT, 16'd0);
        word(1'b1, 2'b11);
        expect_ev(EV_SLIP);
        chk("mis_slip_count", SLIP_COUNT, exp_stat(1));
        wait_ignored();
        acquire();
        chk("mis_locked", {15'd0, LOCKED}, 16'd1);
        chk("mis_final_slip_count", SLIP_COUNT, exp_stat(1));

        // Unstrobed invalid headers in HUNT are ignored
        do_reset(1'b1);
        for (int i = 0; i < 63; i++) begin
            good_word();
            word(1'b0, 2'b00);
        end
        good_word();
        expect_ev(EV_UP);
        chk("gate_locked", {15'd0, LOCKED}, 16'd1);

        // Reset during WAIT returns straight to HUNT
        do_reset(1'b1);
        word(1'b1, 2'b00);
        expect_ev(EV_SLIP);
        for (int i = 0; i < 10; i++) word(1'b1, 2'b00);
        chk("pre_rst_slip_count", SLIP_COUNT, exp_stat(1));
        do_reset(1'b0);
        chk("rst_wait_slip", {15'd0, SLIP}, 16'd0);
        chk("rst_wait_locked", {15'd0, LOCKED}, 16'd0);
        chk("rst_wait_slip_count", SLIP_COUNT, 16'd0);
        chk("rst_wait_loss_count", LOCK_LOSS_COUNT, 16'd0);
        acquire();
        chk("rst_wait_relock", {15'd0, LOCKED}, 16'd1);

        // Saturation of the statistics counter
        DATA_VALID = 1'b0;
        chk("sat_cleared", sat_cnt, 16'h0000);
        sat_clr = 1'b0;
        sat_inc = 1'b1;
        repeat (65534) @(posedge USER_CLK);
        #1;
        chk("sat_fffe", sat_cnt, 16'hFFFE);
        @(posedge USER_CLK);
        #1;
        chk("sat_ffff", sat_cnt, 16'hFFFF);
        repeat (3) @(posedge USER_CLK);
        #1;
        chk("sat_hold", sat_cnt, 16'hFFFF);
        sat_inc = 1'b0;
        sat_clr = 1'b1;
        @(posedge USER_CLK);
        #1;
        chk("sat_clear", sat_cnt, 16'h0000);

        repeat (2) @(posedge USER_CLK);
        #1;
        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_errors++;
            $error("FAIL pending_events observed %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
